// File: rtl/i2s_pkg.sv
// i2s_pkg: mode encoding and default parameters shared by the I2S transmitter files.
package i2s_pkg;
    localparam logic I2S_MODE_PHILIPS = 1'b0;
    localparam logic I2S_MODE_LJ = 1'b1;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_SLOT_W = 16;
    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: show-ahead synchronous FIFO holding left/right sample pairs.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_SAMPLE_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    // Pointers carry one extra wrap bit so their difference is the occupancy.
    assign level = wr_ptr - rd_ptr;
    assign empty = level == '0;
    assign full = level == LW'(DEPTH);
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + LW'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + LW'(1);
        end
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/i2s_stream_tx.sv
// i2s_stream_tx: FIFO-buffered I2S / left-justified serializer with a generated bit clock.
module i2s_stream_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int SLOT_W = DEF_SLOT_W,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mode,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic [SAMPLE_W-1:0]           sample_left,
    input  logic [SAMPLE_W-1:0]           sample_right,
    output logic                          bit_clock,
    output logic                          word_select,
    output logic                          sound_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);
    localparam int FRAME = 2 * SLOT_W;
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME);
    localparam logic [BW-1:0] LAST_B = BW'(FRAME - 1);
    localparam logic [BW-1:0] SLOT_B = BW'(SLOT_W);
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] b, b_nx, b_ws, k, pos;
    logic tick, mode_r, eff_mode, load, empty, full;
    logic [2*SAMPLE_W-1:0] fifo_dout, active, frame_data;
    logic [SAMPLE_W-1:0] chan, shifted;
    i2s_sample_fifo #(.WIDTH(2 * SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_valid && sample_ready),
        .pop   (load && !empty),
        .din   ({sample_left, sample_right}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );
    assign sample_ready = !full;
    assign bit_clock = div_cnt >= DW'(CLK_DIV / 2);
    assign tick = enable && (div_cnt == DW'(CLK_DIV - 1));
    assign b_nx = (b == LAST_B) ? '0 : b + BW'(1);
    assign b_ws = (b_nx == LAST_B) ? '0 : b_nx + BW'(1);
    // The frame's mode is latched entering b = 0, so that tick already uses the live input.
    assign eff_mode = (b_nx == '0) ? mode : mode_r;
    assign k = (eff_mode == I2S_MODE_LJ) ? b_nx : ((b_nx == '0) ? LAST_B : b_nx - BW'(1));
    assign load = tick && (b_nx == ((eff_mode == I2S_MODE_PHILIPS) ? BW'(1) : BW'(0)));
    assign frame_data = load ? (empty ? '0 : fifo_dout) : active;
    assign chan = (k < SLOT_B) ? frame_data[2*SAMPLE_W-1:SAMPLE_W] : frame_data[SAMPLE_W-1:0];
    assign pos = (k < SLOT_B) ? k : k - SLOT_B;
    // Shifting past the sample width yields the zero padding of wide slots.
    assign shifted = chan << pos;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            div_cnt <= '0;
            b <= LAST_B;
            word_select <= 1'b0;
            sound_data <= 1'b0;
            underrun <= 1'b0;
            mode_r <= I2S_MODE_PHILIPS;
            active <= '0;
        end else begin
            underrun <= load && empty;
            if (!enable) begin
                div_cnt <= '0;
                b <= LAST_B;
                word_select <= 1'b0;
                sound_data <= 1'b0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
                if (tick) begin
                    b <= b_nx;
                    word_select <= (eff_mode == I2S_MODE_LJ) ? (b_nx >= SLOT_B) : (b_ws >= SLOT_B);
                    sound_data <= shifted[SAMPLE_W-1];
                end
                if (tick && b_nx == '0) mode_r <= mode;
                if (load) active <= frame_data;
            end
        end
endmodule

// File: tb/tb_i2s_stream_tx.sv
// tb_i2s_stream_tx: directed stimulus on two transmitter configurations, checked against a frame-level model.
module tb_i2s_stream_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mode = 1'b0;
    logic [15:0] left = '0, right = '0;
    logic [1:0] en = '0, vld = '0;
    logic [1:0] bck, wsel, sdat, rdy, und;
    logic [2:0] lvl [2];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic bitof(input logic [31:0] pr, input int k, input int sl);
        int p;
        logic [15:0] ch;
        p = k % sl;
        ch = (k < sl) ? pr[31:16] : pr[15:0];
        return (p < 16) ? ch[15-p] : 1'b0;
    endfunction
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int SL = (g == 0) ? 16 : 24;
        localparam int N = 2 * SL;
        logic [31:0] q [$];
        logic [31:0] act = '0;
        int t = 0;
        int mb = N - 1;
        logic mmode = 1'b0;
        logic m_ws = 1'b0, m_sd = 1'b0, m_und = 1'b0, psh;
        i2s_stream_tx #(.SAMPLE_W(16), .SLOT_W(SL), .CLK_DIV(4), .FIFO_DEPTH(4)) dut (
            .clk          (clk),
            .rst          (rst),
            .enable       (en[g]),
            .mode         (mode),
            .sample_valid (vld[g]),
            .sample_ready (rdy[g]),
            .sample_left  (left),
            .sample_right (right),
            .bit_clock    (bck[g]),
            .word_select  (wsel[g]),
            .sound_data   (sdat[g]),
            .fifo_level   (lvl[g]),
            .underrun     (und[g])
        );
        // t counts enabled clk edges; every 4th one is a bit-clock falling edge.
        initial forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                act = '0;
                t = 0;
                mb = N - 1;
                mmode = 1'b0;
                m_ws = 1'b0;
                m_sd = 1'b0;
                m_und = 1'b0;
            end else begin
                psh = vld[g] && (q.size() < 4);
                m_und = 1'b0;
                if (!en[g]) begin
                    t = 0;
                    mb = N - 1;
                    m_ws = 1'b0;
                    m_sd = 1'b0;
                end else begin
                    t++;
                    if (t % 4 == 0) begin
                        mb = (mb + 1) % N;
                        if (mb == 0) mmode = mode;
                        if (mb == (mmode ? 0 : 1)) begin
                            if (q.size() > 0) act = q.pop_front();
                            else begin
                                act = '0;
                                m_und = 1'b1;
                            end
                        end
                        m_ws = mmode ? (mb >= SL) : (((mb + 1) % N) >= SL);
                        m_sd = bitof(act, mmode ? mb : (mb + N - 1) % N, SL);
                    end
                end
                if (psh) q.push_back({left, right});
            end
        end
        initial forever begin
            @(negedge clk);
            chk($sformatf("u%0d.bit_clock", g), 48'(bck[g]), 48'((t % 4) >= 2));
            chk($sformatf("u%0d.word_select", g), 48'(wsel[g]), 48'(m_ws));
            chk($sformatf("u%0d.sound_data", g), 48'(sdat[g]), 48'(m_sd));
            chk($sformatf("u%0d.underrun", g), 48'(und[g]), 48'(m_und));
            chk($sformatf("u%0d.sample_ready", g), 48'(rdy[g]), 48'(q.size() < 4));
            chk($sformatf("u%0d.fifo_level", g), 48'(lvl[g]), 48'(q.size()));
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic [3:0] bcap;
        logic [32:0] cap_sd, cap_ws;
        logic [47:0] c1sd, c1ws;
        logic [15:0] w1, w2;
        int c1, c2, ones;
        bit ok;
        #12;
        chk("rst_bit_clock", 48'(bck[0]), 0);
        chk("rst_word_select", 48'(wsel[0]), 0);
        chk("rst_sound_data", 48'(sdat[0]), 0);
        chk("rst_ready", 48'(rdy[0]), 1);
        chk("rst_level", 48'(lvl[0]), 0);
        chk("rst_underrun", 48'(und[0]), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        left = 16'hA5F0;
        right = 16'h0F0F;
        vld[0] = 1'b1;
        @(posedge clk); #2;
        vld[0] = 1'b0;
        chk("level_after_push", 48'(lvl[0]), 1);
        en[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bcap[i] = bck[0];
        end
        chk("bit_clock_period", 48'(bcap), 48'(4'b0110));
        cap_sd[0] = sdat[0];
        cap_ws[0] = wsel[0];
        for (int j = 1; j < 33; j++) begin
            repeat (4) @(posedge clk);
            #1;
            cap_sd[j] = sdat[0];
            cap_ws[j] = wsel[0];
        end
        for (int p = 0; p < 16; p++) begin
            w1[15-p] = cap_sd[1+p];
            w2[15-p] = cap_sd[17+p];
        end
        chk("i2s_b0_prev_right", 48'(cap_sd[0]), 0);
        chk("i2s_left_word", 48'(w1), 48'(16'hA5F0));
        chk("i2s_right_word", 48'(w2), 48'(16'h0F0F));
        chk("i2s_word_select", 48'(cap_ws), 48'(33'h0_7FFF_8000));
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (und[0]) begin
                ok = 1'b1;
                c1 = cyc;
            end
        end
        chk("underrun_first_seen", 48'(ok), 1);
        ok = 1'b0;
        ones = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (sdat[0]) ones++;
            if (und[0]) begin
                ok = 1'b1;
                c2 = cyc;
            end
        end
        chk("underrun_second_seen", 48'(ok), 1);
        chk("underrun_interval", 48'(c2 - c1), 128);
        chk("underrun_silence", 48'(ones), 0);
        @(posedge clk); #2;
        en[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            left = 16'h1000 + 16'(i);
            right = 16'h2000 + 16'(i);
            vld[0] = 1'b1;
            @(posedge clk); #2;
            chk($sformatf("fill_level_%0d", i), 48'(lvl[0]), 48'(i + 1));
            chk($sformatf("fill_ready_%0d", i), 48'(rdy[0]), 48'(i < 3));
        end
        left = 16'h1004;
        right = 16'h2004;
        en[0] = 1'b1;
        for (int i = 0; i < 300 && !rdy[0]; i++) begin
            @(posedge clk); #2;
        end
        chk("fifth_ready_after_pop", 48'(rdy[0]), 1);
        chk("level_after_first_pop", 48'(lvl[0]), 3);
        @(posedge clk); #2;
        vld[0] = 1'b0;
        chk("level_after_fifth_push", 48'(lvl[0]), 4);
        repeat (128) @(posedge clk);
        #2;
        chk("level_one_frame_later", 48'(lvl[0]), 3);
        repeat (37) @(posedge clk);
        #2;
        mode = 1'b1;
        repeat (300) @(posedge clk);
        #2;
        mode = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        mode = 1'b1;
        left = 16'h8001;
        right = 16'hC000;
        vld[1] = 1'b1;
        @(posedge clk); #2;
        vld[1] = 1'b0;
        en[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        c1sd[0] = sdat[1];
        c1ws[0] = wsel[1];
        for (int j = 1; j < 48; j++) begin
            repeat (4) @(posedge clk);
            #1;
            c1sd[j] = sdat[1];
            c1ws[j] = wsel[1];
        end
        chk("lj_msb_b0", 48'(c1sd[0]), 1);
        chk("lj_ws_b0", 48'(c1ws[0]), 0);
        chk("lj_mid_bits", 48'(c1sd[14:1]), 0);
        chk("lj_lsb_b15", 48'(c1sd[15]), 1);
        chk("lj_padding", 48'(c1sd[23:16]), 0);
        chk("lj_ws_b23", 48'(c1ws[23]), 0);
        chk("lj_ws_b24", 48'(c1ws[24]), 1);
        chk("lj_right_msb_b24", 48'(c1sd[24]), 1);
        @(posedge clk); #2;
        vld[0] = 1'b1;
        left = 16'h1234;
        right = 16'h5678;
        repeat (2) @(posedge clk);
        #2;
        vld[0] = 1'b0;
        for (int i = 0; i < 8 && !bck[0]; i++) begin
            @(posedge clk); #2;
        end
        chk("bit_clock_high_before_rst", 48'(bck[0]), 1);
        rst = 1'b0;
        #1;
        chk("midrst_bit_clock", 48'(bck[0]), 0);
        chk("midrst_word_select", 48'(wsel[0]), 0);
        chk("midrst_sound_data", 48'(sdat[0]), 0);
        chk("midrst_ready", 48'(rdy[0]), 1);
        chk("midrst_level", 48'(lvl[0]), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_no_underrun", 48'(und[0]), 0);
        end
        @(posedge clk); #1;
        chk("post_rst_b0_underrun", 48'(und[0]), 1);
        chk("post_rst_b0_ws", 48'(wsel[0]), 0);
        repeat (300) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
